// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first.
// A single full adder and a carry flip-flop are reused across WIDTH cycles.
// The result and carry-out are presented together with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Enough counter bits to index every bit position of one operation.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             bit_sum;
  logic             carry_next;
  logic             last_bit;

  // One full adder slice on the current LSBs and the stored carry.
  assign bit_sum    = op_a_reg[0] ^ op_b_reg[0] ^ carry_reg;
  assign carry_next = (op_a_reg[0] & op_b_reg[0]) |
                      (op_a_reg[0] & carry_reg)   |
                      (op_b_reg[0] & carry_reg);
  assign last_bit   = (cnt_reg == CNT_LAST);

  assign sum  = sum_reg;
  assign cout = cout_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE always lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      RUN:     busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, serial shifting and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      sum_sh_reg <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_a_reg  <= a;
            op_b_reg  <= b;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          op_a_reg   <= {1'b0, op_a_reg[WIDTH-1:1]};
          op_b_reg   <= {1'b0, op_b_reg[WIDTH-1:1]};
          sum_sh_reg <= {bit_sum, sum_sh_reg[WIDTH-1:1]};
          carry_reg  <= carry_next;
          if (last_bit) begin
            // Publish the finished word including the bit computed this cycle;
            // the counter is held so it never wraps within an operation.
            sum_reg  <= {bit_sum, sum_sh_reg[WIDTH-1:1]};
            cout_reg <= carry_next;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with WIDTH=8: a table of additions plus
// hand-written sequences for ignored start, mid-run reset and back-to-back issue.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_pass   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one addition, wait for done, check latency, held result and final result.
  task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] es, input logic ec,
                        input logic [W-1:0] hs, input logic hc);
    int n;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 4) begin
        chk("sum_held_in_run", 32'(sum), 32'(hs));
        chk("cout_held_in_run", 32'(cout), 32'(hc));
      end
    end
    chk("done_latency", 32'(n), 32'd8);
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    $display("add a=%02h b=%02h -> sum=%02h cout=%0d after %0d cycles", va, vb, sum, cout, n);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int busy_cnt;
    int done_cnt;
    int first_t;
    int last_t;
    logic [W-1:0] prev_s;
    logic         prev_c;

    vecs[0] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0};
    vecs[4] = '{a: 8'h3C, b: 8'h0F, s: 8'h4B, c: 1'b0};
    vecs[5] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start_busy", 32'(busy), 32'd0);

    // Table of additions; each checks that the previous result is held during RUN.
    prev_s = '0; prev_c = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, prev_s, prev_c);
      prev_s = vecs[i].s;
      prev_c = vecs[i].c;
    end

    // start and operand changes during RUN are ignored.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    a = 8'hFF; b = 8'hFF;
    busy_cnt = 0; done_cnt = 0;
    for (int t = 0; t < 14; t++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("ign_sum", 32'(sum), 32'h46);
        chk("ign_cout", 32'(cout), 32'd0);
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("ign_done_pulses", 32'(done_cnt), 32'd1);
    $display("ignore-start run: busy %0d cycles, %0d done pulse(s), sum=%02h", busy_cnt, done_cnt, sum);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    $display("mid-run reset: %0d done pulse(s) afterwards", done_cnt);
    do_add(8'h01, 8'h02, 8'h03, 1'b0, 8'h00, 1'b0);

    // start held high: done every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    done_cnt = 0; first_t = -1; last_t = -1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (done) begin
        if (done_cnt > 0) chk("b2b_interval", 32'(t - last_t), 32'd10);
        if (first_t < 0) first_t = t;
        last_t = t;
        done_cnt++;
        chk("b2b_sum", 32'(sum), 32'h02);
        chk("b2b_cout", 32'(cout), 32'd0);
        $display("back-to-back done at cycle %0d sum=%02h cout=%0d", t, sum, cout);
      end
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(first_t), 32'd9);
    chk("b2b_pulses", 32'(done_cnt), 32'd3);
    repeat (12) @(negedge clk);
    chk("b2b_final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
